tx_nchannel_pkt_arbiter: RTL

TX_NCHANNEL_PKT_ARBITER -- requirements
Module: tx_nchannel_pkt_arbiter

---
 rtl/tx_nchannel_pkt_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/tx_nchannel_pkt_arbiter.sv
// Packet-granular round-robin arbiter: N request channels share one registered
// output beat stream; a channel keeps the grant from lock until its eop beat.
//
// state | meaning
// IDLE  | no grant; arbitrate from ptr when downstream is ready
// LOCK  | channel g owns the output until eop or stall abort
module tx_nchannel_pkt_arbiter #(
    parameter int         NUM_CHANS     = 4,
    parameter int         LOG_CHANS     = 2,
    parameter int         NUM_DAT_WORDS = 8,
    parameter int         LOG_DAT_WORDS = 4,
    parameter logic [7:0] CHANID_BASE   = 8'h0,
    parameter int         STALL_LIMIT   = 255
) (
    input  logic                                  clk,
    input  logic                                  arst,
    input  logic [NUM_CHANS*LOG_DAT_WORDS-1:0]    in_num_valid,
    input  logic [NUM_CHANS*64*NUM_DAT_WORDS-1:0] in_words,
    input  logic [NUM_CHANS-1:0]                  in_sop,
    input  logic [NUM_CHANS*4-1:0]                in_eopbits,
    input  logic [NUM_CHANS-1:0]                  in_valid,
    output logic [NUM_CHANS-1:0]                  in_ready,
    output logic [LOG_DAT_WORDS-1:0]              num_datwords_valid,
    output logic [64*NUM_DAT_WORDS-1:0]           datwords,
    output logic [7:0]                            chan,
    output logic                                  sop,
    output logic [3:0]                            eopbits,
    input  logic                                  ready,
    output logic                                  valid,
    output logic                                  abort,
    output logic                                  sop_err
);

    localparam int          WW        = 64 * NUM_DAT_WORDS;
    localparam int          LDW       = LOG_DAT_WORDS;
    localparam logic [15:0] STALL_MAX = 16'(STALL_LIMIT);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_LOCK = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [LOG_CHANS-1:0] g_q, g_d;
    logic [LOG_CHANS-1:0] ptr_q, ptr_d;
    logic [15:0]          stall_q, stall_d;
    logic                 mid_q, mid_d;
    logic [LDW-1:0]       nv_q, nv_d;
    logic [WW-1:0]        words_q, words_d;
    logic [7:0]           chan_q, chan_d;
    logic                 sop_q, sop_d;
    logic [3:0]           eop_q, eop_d;
    logic                 abort_q, abort_d;
    logic                 sop_err_q, sop_err_d;

    logic [NUM_CHANS-1:0] qual;
    logic                 win_found;
    logic [LOG_CHANS-1:0] win_idx;
    int                   scan;
    logic [LDW-1:0]       cur_cnt;
    logic [WW-1:0]        cur_words;
    logic                 cur_sop;
    logic [3:0]           cur_eop;
    logic                 cur_valid;
    logic                 locked;
    logic                 xfer;
    logic [LOG_CHANS-1:0] g_next;
    logic [15:0]          stall_inc;

    always_comb begin
        qual      = '0;
        cur_cnt   = '0;
        cur_words = '0;
        cur_sop   = 1'b0;
        cur_eop   = '0;
        cur_valid = 1'b0;
        for (int i = 0; i < NUM_CHANS; i++) begin
            qual[i] = in_valid[i] && (in_num_valid[i*LDW +: LDW] != '0);
            if (g_q == LOG_CHANS'(i)) begin
                cur_cnt   = in_num_valid[i*LDW +: LDW];
                cur_words = in_words[i*WW +: WW];
                cur_sop   = in_sop[i];
                cur_eop   = in_eopbits[i*4 +: 4];
                cur_valid = in_valid[i];
            end
        end
    end

    // Scan from farthest to nearest so the last hit is the first at/after ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = 0;
        for (int k = NUM_CHANS - 1; k >= 0; k--) begin
            scan = (int'(ptr_q) + k) % NUM_CHANS;
            if (qual[LOG_CHANS'(scan)]) begin
                win_found = 1'b1;
                win_idx   = LOG_CHANS'(scan);
            end
        end
    end

    assign locked    = (state_q == S_LOCK);
    assign xfer      = locked && ready && cur_valid && (cur_cnt != '0);
    assign g_next    = (g_q == LOG_CHANS'(NUM_CHANS - 1)) ? '0 : g_q + LOG_CHANS'(1);
    assign stall_inc = (stall_q >= STALL_MAX) ? stall_q : stall_q + 16'd1;

    always_comb begin
        in_ready = '0;
        if (locked && ready) begin
            in_ready[g_q] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        ptr_d     = ptr_q;
        stall_d   = stall_q;
        mid_d     = mid_q;
        nv_d      = nv_q;
        words_d   = words_q;
        chan_d    = chan_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        abort_d   = 1'b0;
        sop_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall_d = '0;
                mid_d   = 1'b0;
                if (ready) begin
                    nv_d = '0;
                    if (win_found) begin
                        state_d = S_LOCK;
                        g_d     = win_idx;
                    end
                end
            end
            default: begin
                if (xfer) begin
                    nv_d      = cur_cnt;
                    words_d   = cur_words;
                    chan_d    = CHANID_BASE + 8'(g_q);
                    sop_d     = cur_sop;
                    eop_d     = cur_eop;
                    stall_d   = '0;
                    sop_err_d = cur_sop && mid_q;
                    if (cur_eop[3]) begin
                        state_d = S_IDLE;
                        ptr_d   = g_next;
                        mid_d   = 1'b0;
                    end else begin
                        mid_d = 1'b1;
                    end
                end else if (ready) begin
                    nv_d    = '0;
                    stall_d = stall_inc;
                    if (stall_inc == STALL_MAX) begin
                        state_d = S_IDLE;
                        ptr_d   = g_next;
                        abort_d = 1'b1;
                        stall_d = '0;
                        mid_d   = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= S_IDLE;
            g_q       <= '0;
            ptr_q     <= '0;
            stall_q   <= '0;
            mid_q     <= 1'b0;
            nv_q      <= '0;
            words_q   <= '0;
            chan_q    <= '0;
            sop_q     <= 1'b0;
            eop_q     <= '0;
            abort_q   <= 1'b0;
            sop_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            ptr_q     <= ptr_d;
            stall_q   <= stall_d;
            mid_q     <= mid_d;
            nv_q      <= nv_d;
            words_q   <= words_d;
            chan_q    <= chan_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            abort_q   <= abort_d;
            sop_err_q <= sop_err_d;
        end
    end

    assign num_datwords_valid = nv_q;
    assign datwords           = words_q;
    assign chan               = chan_q;
    assign sop                = sop_q;
    assign eopbits            = eop_q;
    assign valid              = |nv_q;
    assign abort              = abort_q;
    assign sop_err            = sop_err_q;

endmodule
